// File: rtl/ovl_win_unchange_checker.sv
// ovl_win_unchange_checker: evaluation stage of a window-unchange checker.
// Captures the reference value when a window opens. Flags any change of
// test_expr while the window is open. Keeps saturating window and violation
// counts, and cross-checks the upstream window flag against a local shadow.
module ovl_win_unchange_checker #(
  parameter int unsigned width     = 8,
  parameter int unsigned cnt_width = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 enable,
  input  logic                 start_event,
  input  logic                 end_event,
  input  logic [width-1:0]     test_expr,
  input  logic                 window,
  output logic                 fire,
  output logic                 fire_sticky,
  output logic [width-1:0]     ref_value,
  output logic [width-1:0]     bad_value,
  output logic [cnt_width-1:0] window_count,
  output logic [cnt_width-1:0] violation_count,
  output logic                 cover_open,
  output logic                 cover_close,
  output logic                 proto_err
);

  localparam int unsigned cw = cnt_width;

  // Saturating increment: holds at all-ones instead of wrapping.
  function automatic logic [cw-1:0] sat_inc(input logic [cw-1:0] v);
    return (&v) ? v : v + cw'(1);
  endfunction

  logic sw;
  logic sw_nxt_c;
  logic open_c;
  logic close_c;
  logic mismatch_c;
  logic viol_c;

  // Event decode and shadow window next state. The shadow follows the same
  // rule as the upstream logic and ignores enable.
  always_comb begin
    open_c     = !window && start_event;
    close_c    = window && end_event;
    mismatch_c = window && (test_expr != ref_value);
    viol_c     = mismatch_c && enable;
    sw_nxt_c   = sw;
    if (!sw && start_event) begin
      sw_nxt_c = 1'b1;
    end else if (sw && end_event) begin
      sw_nxt_c = 1'b0;
    end
  end

  // Registered state and outputs. Reset overrides every update, so pending
  // pulses are dropped.
  always_ff @(posedge clk) begin
    if (reset) begin
      sw              <= 1'b0;
      fire            <= 1'b0;
      fire_sticky     <= 1'b0;
      ref_value       <= '0;
      bad_value       <= '0;
      window_count    <= '0;
      violation_count <= '0;
      cover_open      <= 1'b0;
      cover_close     <= 1'b0;
      proto_err       <= 1'b0;
    end else begin
      sw          <= sw_nxt_c;
      proto_err   <= (window != sw);
      cover_open  <= open_c;
      cover_close <= close_c;
      fire        <= viol_c;
      if (viol_c) begin
        fire_sticky     <= 1'b1;
        bad_value       <= test_expr;
        violation_count <= sat_inc(violation_count);
      end
      // Re-arm on every mismatch so that one change fires only once.
      if (open_c || mismatch_c) begin
        ref_value <= test_expr;
      end
      if (close_c && enable) begin
        window_count <= sat_inc(window_count);
      end
    end
  end

endmodule

// File: tb/tb_ovl_win_unchange_checker.sv
// Directed bench for ovl_win_unchange_checker. Stimulus pushes expected
// post-edge outputs into a queue. A monitor pops and compares after each edge.
// A second instance with 2-bit counters covers saturation.
module tb_ovl_win_unchange_checker;

  logic       clk = 1'b0;
  logic       reset, enable, start_event, end_event, window;
  logic [7:0] test_expr;

  logic        d_fire, d_sticky, d_open, d_close, d_perr;
  logic [7:0]  d_ref, d_bad;
  logic [15:0] d_wc, d_vc;
  logic        s_fire, s_sticky, s_open, s_close, s_perr;
  logic [7:0]  s_ref, s_bad;
  logic [1:0]  s_wc, s_vc;

  always #5 clk = ~clk;

  ovl_win_unchange_checker #(.width(8), .cnt_width(16)) dut (
    .clk(clk), .reset(reset), .enable(enable), .start_event(start_event),
    .end_event(end_event), .test_expr(test_expr), .window(window),
    .fire(d_fire), .fire_sticky(d_sticky), .ref_value(d_ref), .bad_value(d_bad),
    .window_count(d_wc), .violation_count(d_vc), .cover_open(d_open),
    .cover_close(d_close), .proto_err(d_perr)
  );

  ovl_win_unchange_checker #(.width(8), .cnt_width(2)) dut_sat (
    .clk(clk), .reset(reset), .enable(enable), .start_event(start_event),
    .end_event(end_event), .test_expr(test_expr), .window(window),
    .fire(s_fire), .fire_sticky(s_sticky), .ref_value(s_ref), .bad_value(s_bad),
    .window_count(s_wc), .violation_count(s_vc), .cover_open(s_open),
    .cover_close(s_close), .proto_err(s_perr)
  );

  typedef struct {
    logic        fire, sticky, open, close, perr;
    logic [7:0]  refv, bad;
    logic [15:0] wc, vc;
    logic [1:0]  wcs, vcs;
  } exp_t;

  exp_t q[$];
  int vectors = 0;
  int miscompares = 0;

  // Expected persistent outputs after the next edge, set by hand per test.
  logic        e_sticky;
  logic [7:0]  e_ref, e_bad;
  logic [15:0] e_wc, e_vc;

  function automatic logic [1:0] sat2(input logic [15:0] v);
    return (v > 16'd3) ? 2'd3 : v[1:0];
  endfunction

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Apply one cycle of inputs and queue the outputs expected after its edge.
  task automatic step(input logic r, input logic en, input logic st, input logic ev,
                      input logic win, input logic [7:0] tx,
                      input logic f, input logic o, input logic c, input logic p);
    exp_t e;
    @(negedge clk);
    reset = r; enable = en; start_event = st; end_event = ev;
    window = win; test_expr = tx;
    e.fire = f; e.open = o; e.close = c; e.perr = p;
    e.sticky = e_sticky; e.refv = e_ref; e.bad = e_bad;
    e.wc = e_wc; e.vc = e_vc; e.wcs = sat2(e_wc); e.vcs = sat2(e_vc);
    q.push_back(e);
  endtask

  task automatic clr_exp();
    e_sticky = 1'b0; e_ref = 8'h00; e_bad = 8'h00; e_wc = 16'd0; e_vc = 16'd0;
  endtask

  task automatic do_reset();
    clr_exp();
    step(1, 1, 0, 0, 0, 8'h00, 0, 0, 0, 0);
  endtask

  // Monitor: compare both instances against each queued expectation.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        exp_t e;
        e = q.pop_front();
        vectors++;
        chk("fire",        16'(d_fire),   16'(e.fire));
        chk("fire_sticky", 16'(d_sticky), 16'(e.sticky));
        chk("cover_open",  16'(d_open),   16'(e.open));
        chk("cover_close", 16'(d_close),  16'(e.close));
        chk("proto_err",   16'(d_perr),   16'(e.perr));
        chk("ref_value",   16'(d_ref),    16'(e.refv));
        chk("bad_value",   16'(d_bad),    16'(e.bad));
        chk("window_count",    d_wc,      e.wc);
        chk("violation_count", d_vc,      e.vc);
        chk("sat_fire",        16'(s_fire),   16'(e.fire));
        chk("sat_fire_sticky", 16'(s_sticky), 16'(e.sticky));
        chk("sat_cover_open",  16'(s_open),   16'(e.open));
        chk("sat_cover_close", 16'(s_close),  16'(e.close));
        chk("sat_proto_err",   16'(s_perr),   16'(e.perr));
        chk("sat_ref_value",   16'(s_ref),    16'(e.refv));
        chk("sat_bad_value",   16'(s_bad),    16'(e.bad));
        chk("sat_window_count",    16'(s_wc), 16'(e.wcs));
        chk("sat_violation_count", 16'(s_vc), 16'(e.vcs));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1; enable = 1'b1; start_event = 1'b0; end_event = 1'b0;
    window = 1'b0; test_expr = 8'h00;
    clr_exp();

    // Clean window: open at cycle 2, close at cycle 6, value held.
    do_reset();
    step(0, 1, 0, 0, 0, 8'hA5, 0, 0, 0, 0);
    step(0, 1, 0, 0, 0, 8'hA5, 0, 0, 0, 0);
    e_ref = 8'hA5;
    step(0, 1, 1, 0, 0, 8'hA5, 0, 1, 0, 0);
    repeat (3) step(0, 1, 0, 0, 1, 8'hA5, 0, 0, 0, 0);
    e_wc = 16'd1;
    step(0, 1, 0, 1, 1, 8'hA5, 0, 0, 1, 0);
    step(0, 1, 0, 0, 0, 8'hA5, 0, 0, 0, 0);

    // Single violation at cycle 4, value held afterwards.
    do_reset();
    step(0, 1, 0, 0, 0, 8'hA5, 0, 0, 0, 0);
    step(0, 1, 0, 0, 0, 8'hA5, 0, 0, 0, 0);
    e_ref = 8'hA5;
    step(0, 1, 1, 0, 0, 8'hA5, 0, 1, 0, 0);
    step(0, 1, 0, 0, 1, 8'hA5, 0, 0, 0, 0);
    e_ref = 8'h5A; e_bad = 8'h5A; e_vc = 16'd1; e_sticky = 1'b1;
    step(0, 1, 0, 0, 1, 8'h5A, 1, 0, 0, 0);
    step(0, 1, 0, 0, 1, 8'h5A, 0, 0, 0, 0);
    e_wc = 16'd1;
    step(0, 1, 0, 1, 1, 8'h5A, 0, 0, 1, 0);
    step(0, 1, 0, 0, 0, 8'h5A, 0, 0, 0, 0);
    step(0, 1, 0, 0, 0, 8'h5A, 0, 0, 0, 0);

    // Change in the close cycle; then the same with enable low.
    do_reset();
    e_ref = 8'hA5;
    step(0, 1, 1, 0, 0, 8'hA5, 0, 1, 0, 0);
    step(0, 1, 0, 0, 1, 8'hA5, 0, 0, 0, 0);
    e_ref = 8'h3C; e_bad = 8'h3C; e_vc = 16'd1; e_wc = 16'd1; e_sticky = 1'b1;
    step(0, 1, 0, 1, 1, 8'h3C, 1, 0, 1, 0);
    step(0, 1, 0, 0, 0, 8'h3C, 0, 0, 0, 0);
    e_ref = 8'h11;
    step(0, 0, 1, 0, 0, 8'h11, 0, 1, 0, 0);
    step(0, 0, 0, 0, 1, 8'h11, 0, 0, 0, 0);
    e_ref = 8'h22;
    step(0, 0, 0, 1, 1, 8'h22, 0, 0, 1, 0);
    step(0, 0, 0, 0, 0, 8'h22, 0, 0, 0, 0);

    // Saturation: five windows with one violation each.
    do_reset();
    for (int k = 0; k < 5; k++) begin
      e_ref = 8'h10 + 8'(k);
      step(0, 1, 1, 0, 0, 8'h10 + 8'(k), 0, 1, 0, 0);
      e_ref = 8'h80 + 8'(k); e_bad = 8'h80 + 8'(k);
      e_vc = 16'(k + 1); e_sticky = 1'b1;
      step(0, 1, 0, 0, 1, 8'h80 + 8'(k), 1, 0, 0, 0);
      e_wc = 16'(k + 1);
      step(0, 1, 0, 1, 1, 8'h80 + 8'(k), 0, 0, 1, 0);
    end
    step(0, 1, 0, 0, 0, 8'h00, 0, 0, 0, 0);

    // Reset mid-window with a pending violation, then reopen.
    do_reset();
    step(0, 1, 0, 0, 0, 8'h00, 0, 0, 0, 0);
    step(0, 1, 0, 0, 0, 8'h00, 0, 0, 0, 0);
    e_ref = 8'h77;
    step(0, 1, 1, 0, 0, 8'h77, 0, 1, 0, 0);
    e_ref = 8'h78; e_bad = 8'h78; e_vc = 16'd1; e_sticky = 1'b1;
    step(0, 1, 0, 0, 1, 8'h78, 1, 0, 0, 0);
    clr_exp();
    step(1, 1, 0, 1, 1, 8'h79, 0, 0, 0, 0);
    e_ref = 8'h44;
    step(0, 1, 1, 0, 0, 8'h44, 0, 1, 0, 0);
    step(0, 1, 0, 0, 1, 8'h44, 0, 0, 0, 0);
    e_wc = 16'd1;
    step(0, 1, 0, 1, 1, 8'h44, 0, 0, 1, 0);
    step(0, 1, 0, 0, 0, 8'h44, 0, 0, 0, 0);

    // Protocol mismatch: window high without any start; checking still uses window.
    do_reset();
    step(0, 1, 0, 0, 1, 8'h00, 0, 0, 0, 1);
    e_ref = 8'h09; e_bad = 8'h09; e_vc = 16'd1; e_sticky = 1'b1;
    step(0, 1, 0, 0, 1, 8'h09, 1, 0, 0, 1);
    step(0, 1, 0, 0, 0, 8'h09, 0, 0, 0, 0);

    // Simultaneous start/end: opens when closed, closes without reopen when open.
    do_reset();
    e_ref = 8'h12;
    step(0, 1, 1, 1, 0, 8'h12, 0, 1, 0, 0);
    e_wc = 16'd1;
    step(0, 1, 1, 1, 1, 8'h12, 0, 0, 1, 0);
    step(0, 1, 0, 0, 0, 8'h12, 0, 0, 0, 0);

    repeat (3) @(posedge clk);
    #2;
    if (q.size() != 0) begin
      miscompares++;
      $display("FAIL drain: got %0d pending expected 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
